// File: rtl/oq_header_generator.sv
// Purpose : rebuilds the IOQ module header in front of each payload read back
//           from DRAM packet storage, framing each payload by the descriptor's word_len.
// Latency : the header leaves 2 cycles after desc_wr; payload words leave 1 cycle after acceptance.
// Backpres: out_rdy low freezes the output register and all progress.
//           desc_rdy drops when the 2**DESC_DEPTH_BITS descriptor FIFO is full.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   desc_*                 : descriptor push {word_len, byte_len, dst_oq, src_port}; desc_rdy = not full
//   in_data/in_ctrl/in_wr  : payload words; in_rdy is combinational and is only high in DATA
//   out_data/out_ctrl/out_wr : registered output stage, updated only while out_rdy
//   err_len_mismatch       : one-cycle pulse when in_ctrl disagrees with the word_len framing
//   err_desc_ovf           : one-cycle pulse when a descriptor is pushed into a full FIFO

`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_WORD_LEN_POS
`define IOQ_WORD_LEN_POS 48
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 32
`endif
`ifndef IOQ_BYTE_LEN_POS
`define IOQ_BYTE_LEN_POS 16
`endif
`ifndef IOQ_SRC_PORT_POS
`define IOQ_SRC_PORT_POS 0
`endif

module oq_header_generator #(
  parameter int DATA_WIDTH                      = 64,
  parameter int CTRL_WIDTH                      = DATA_WIDTH/8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = `IO_QUEUE_STAGE_NUM,
  parameter int NUM_OUTPUT_QUEUES               = 8,
  parameter int MAX_PKT                         = 2048,
  parameter int PKT_BYTE_CNT_WIDTH              = $clog2(MAX_PKT),
  parameter int PKT_WORD_CNT_WIDTH              = $clog2(MAX_PKT/CTRL_WIDTH),
  parameter int DESC_DEPTH_BITS                 = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          desc_wr,
  input  logic [NUM_OUTPUT_QUEUES-1:0]  desc_dst_oq,
  input  logic [15:0]                   desc_src_port,
  input  logic [PKT_BYTE_CNT_WIDTH-1:0] desc_byte_len,
  input  logic [PKT_WORD_CNT_WIDTH-1:0] desc_word_len,
  output logic                          desc_rdy,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [CTRL_WIDTH-1:0]         in_ctrl,
  input  logic                          in_wr,
  output logic                          in_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic                          out_wr,
  input  logic                          out_rdy,
  output logic                          err_len_mismatch,
  output logic                          err_desc_ovf
);

  localparam int DEPTH = 2**DESC_DEPTH_BITS;
  localparam logic [DESC_DEPTH_BITS:0] DEPTH_CNT = (DESC_DEPTH_BITS+1)'(DEPTH);

  typedef struct packed {
    logic [PKT_WORD_CNT_WIDTH-1:0] word_len;
    logic [PKT_BYTE_CNT_WIDTH-1:0] byte_len;
    logic [NUM_OUTPUT_QUEUES-1:0]  dst_oq;
    logic [15:0]                   src_port;
  } desc_t;

  typedef enum logic {ST_IDLE, ST_DATA} state_t;

  // ---------------- descriptor FIFO (fall-through) ----------------
  desc_t                      desc_mem [DEPTH];
  logic [DESC_DEPTH_BITS-1:0] wr_ptr;
  logic [DESC_DEPTH_BITS-1:0] rd_ptr;
  logic [DESC_DEPTH_BITS:0]   desc_cnt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  desc_t                      head;

  assign fifo_full  = (desc_cnt == DEPTH_CNT);
  assign fifo_empty = (desc_cnt == '0);
  assign desc_rdy   = !fifo_full;
  assign head       = desc_mem[rd_ptr];
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is accepted then.
  assign push       = desc_wr && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      desc_mem[wr_ptr] <= '{word_len: desc_word_len, byte_len: desc_byte_len,
                            dst_oq: desc_dst_oq, src_port: desc_src_port};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      desc_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   desc_cnt <= desc_cnt + 1'b1;
        2'b01:   desc_cnt <= desc_cnt - 1'b1;
        default: desc_cnt <= desc_cnt;
      endcase
    end
  end

  // ---------------- header word ----------------
  logic [DATA_WIDTH-1:0] hdr_data;

  always_comb begin
    hdr_data = '0;
    hdr_data[`IOQ_WORD_LEN_POS +: PKT_WORD_CNT_WIDTH] = head.word_len;
    hdr_data[`IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES]  = head.dst_oq;
    hdr_data[`IOQ_BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH] = head.byte_len;
    hdr_data[`IOQ_SRC_PORT_POS +: 16]                 = head.src_port;
  end

  // ---------------- framing FSM ----------------
  state_t                        state;
  state_t                        state_nxt;
  logic [PKT_WORD_CNT_WIDTH-1:0] word_cnt;
  logic [PKT_WORD_CNT_WIDTH-1:0] last_idx;
  logic                          is_last;
  logic                          hdr_load;
  logic                          word_acc;

  // word_len - 1 in counter width; word_len == 0 never reaches DATA, so no wrap case matters.
  assign last_idx = head.word_len - 1'b1;
  assign is_last  = (word_cnt == last_idx);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    in_rdy    = 1'b0;
    hdr_load  = 1'b0;
    word_acc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && out_rdy) begin
          hdr_load = 1'b1;
          if (head.word_len == '0) pop = 1'b1;
          else                     state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        in_rdy = out_rdy;
        if (in_wr && out_rdy) begin
          word_acc = 1'b1;
          if (is_last) begin
            pop       = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         word_cnt <= '0;
    else if (hdr_load) word_cnt <= '0;
    else if (word_acc) word_cnt <= word_cnt + 1'b1;
  end

  // ---------------- output register ----------------
  // Frozen while out_rdy is low; a bubble clears only out_wr and leaves data/ctrl as they were.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else if (out_rdy) begin
      if (hdr_load) begin
        out_wr   <= 1'b1;
        out_data <= hdr_data;
        out_ctrl <= IOQ_STAGE_NUM;
      end else if (word_acc) begin
        out_wr   <= 1'b1;
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end else begin
        out_wr   <= 1'b0;
      end
    end
  end

  // ---------------- error pulses ----------------
  // Framing always follows word_len; a ctrl disagreement is only flagged, never used to resync.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_len_mismatch <= 1'b0;
      err_desc_ovf     <= 1'b0;
    end else begin
      err_len_mismatch <= word_acc && (is_last ? (in_ctrl == '0) : (in_ctrl != '0));
      err_desc_ovf     <= desc_wr && fifo_full && !pop;
    end
  end

endmodule
